// File: rtl/uart_transceiver.sv
`timescale 1ns/1ps
// uart_transceiver
//   Full-duplex UART: a TX serializer, an RX deserializer with parity and
//   stop-bit checking, and a first-word-fall-through RX FIFO.
//
//   Parameters: CLK_HZ, BAUD (bit time DIV = round(CLK_HZ/BAUD) clocks),
//   DATA_BITS (5..9, LSB first), PARITY (0 none, 1 odd, 2 even),
//   STOP_BITS (1 or 2), RX_FIFO_DEPTH (power of 2, >= 2).
//
//   Ports:
//     clk, reset (async, active low), init (sync soft clear)
//     rx / tx                    serial line pins, idle high
//     start_send, in_data        TX request (rising edge) and payload
//     tx_busy                    frame in flight
//     out_data, rx_valid, rx_pop RX FIFO head, not-empty flag, pop request
//     rx_frame_err               one-cycle pulse, bad stop bit
//     rx_parity_err              one-cycle pulse, parity mismatch
//     rx_overrun                 sticky, good frame dropped on a full FIFO
//     loopback                   only with UART_LOOPBACK_EN: RX listens to
//                                the internal TX bit, tx pin held high
//
//   Handshake: rx_valid is high whenever out_data holds the FIFO head; the
//   head is consumed on a cycle where rx_valid and rx_pop are both high, and
//   rx_pop on an empty FIFO has no effect.
//
//   Optional feature macro: UART_LOOPBACK_EN.
module uart_transceiver #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 start_send,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 rx_valid,
  input  logic                 rx_pop,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(RX_FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_END   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [0:0]    LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  // Parity bit that makes the frame satisfy the configured rule.
  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- TX ---
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_line;
  logic                 start_prev;
  logic                 tx_tick;
  logic                 tx_accept;

  assign tx_tick   = (tx_cnt == BIT_END);
  // start_prev tracks every cycle, so an edge that arrives while busy is
  // consumed and dropped rather than held for later.
  assign tx_accept = start_send & ~start_prev & ~tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_line    <= 1'b1;
      tx_busy    <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_prev <= start_send;
      if (init) begin
        tx_state <= TX_IDLE;
        tx_cnt   <= '0;
        tx_idx   <= '0;
        tx_line  <= 1'b1;
        tx_busy  <= 1'b0;
      end else begin
        if (tx_state != TX_IDLE) tx_cnt <= tx_tick ? '0 : tx_cnt + CNT_ONE;
        case (tx_state)
          TX_IDLE: if (tx_accept) begin
            tx_shift <= in_data;
            tx_par   <= par_of(in_data);
            tx_line  <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
          TX_START: if (tx_tick) begin
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: if (tx_tick) begin
            if (tx_idx != LAST_DATA) begin
              tx_idx   <= tx_idx + 4'd1;
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end else begin
              tx_idx <= '0;
              if (PARITY != 0) begin
                tx_line  <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_line  <= 1'b1;
                tx_state <= TX_STOP;
              end
            end
          end
          TX_PARITY: if (tx_tick) begin
            tx_line  <= 1'b1;
            tx_state <= TX_STOP;
          end
          TX_STOP: if (tx_tick) begin
            if (tx_idx[0] != LAST_STOP[0]) begin
              tx_idx <= tx_idx + 4'd1;
            end else begin
              tx_idx   <= '0;
              tx_busy  <= 1'b0;
              tx_state <= TX_IDLE;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ------------------------------------------------------ line routing ---
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  assign tx    = loopback ? 1'b1 : tx_line;
  assign rx_in = loopback ? tx_line : rx;
`else
  assign tx    = tx_line;
  assign rx_in = rx;
`endif

  // ---------------------------------------------------------------- RX ---
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
  } rx_state_t;

  rx_state_t            rx_state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bad;
  logic                 push_req;
  logic                 rx_tick;

  assign rx_tick = (rx_cnt == BIT_END);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // Held high in reset so a low line at release is not seen as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par_bad    <= 1'b0;
      push_req      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      push_req      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      if (init) begin
        rx_state   <= RX_IDLE;
        rx_cnt     <= '0;
        rx_idx     <= '0;
        rx_par_bad <= 1'b0;
      end else begin
        case (rx_state)
          RX_IDLE: if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
          // Half a bit in: still low means a real start bit; from here on
          // every sample lands DIV clocks later, at a bit centre.
          RX_START: begin
            if (rx_cnt != HALF_END) begin
              rx_cnt <= rx_cnt + CNT_ONE;
            end else begin
              rx_cnt <= '0;
              if (rx_s2) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_idx     <= '0;
                rx_par_bad <= 1'b0;
                rx_state   <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            rx_cnt <= rx_tick ? '0 : rx_cnt + CNT_ONE;
            if (rx_tick) begin
              rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
              if (rx_idx != LAST_DATA) begin
                rx_idx <= rx_idx + 4'd1;
              end else begin
                rx_idx   <= '0;
                rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
              end
            end
          end
          // A parity mismatch is only reported once the stop bit is known
          // good, so a frame carries at most one error pulse.
          RX_PARITY: begin
            rx_cnt <= rx_tick ? '0 : rx_cnt + CNT_ONE;
            if (rx_tick) begin
              rx_par_bad <= (rx_s2 != par_of(rx_shift));
              rx_state   <= RX_STOP;
            end
          end
          RX_STOP: begin
            rx_cnt <= rx_tick ? '0 : rx_cnt + CNT_ONE;
            if (rx_tick) begin
              if (!rx_s2) begin
                rx_idx       <= '0;
                rx_frame_err <= 1'b1;
                rx_state     <= RX_WAIT_IDLE;
              end else if (rx_idx[0] != LAST_STOP[0]) begin
                rx_idx <= rx_idx + 4'd1;
              end else begin
                rx_idx   <= '0;
                rx_state <= RX_IDLE;
                if (rx_par_bad) rx_parity_err <= 1'b1;
                else            push_req      <= 1'b1;
              end
            end
          end
          RX_WAIT_IDLE: if (rx_s2) rx_state <= RX_IDLE;
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------- FIFO ---
  logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full, do_pop, do_push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = rx_pop & ~fifo_empty & ~init;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push    = push_req & (~fifo_full | do_pop) & ~init;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_overrun <= 1'b0;
    end else if (init) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && fifo_full && !do_pop) rx_overrun <= 1'b1;
    end
  end

  assign rx_valid = ~fifo_empty;
  assign out_data = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
// Bench for uart_transceiver: a default 8N1 instance at 115200 baud and a
// fast even-parity instance whose tx can be looped into its own rx.
module tb_uart_transceiver;

  localparam int W       = 8;
  localparam int DIV1    = 434;
  localparam int BIT_NS  = 8680;
  localparam int DIV2    = 16;
  localparam int BIT2_NS = 320;

  // ---------------------------------------------- clock / reset block ---
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------- instance 1 (8N1) ---
  logic         init = 1'b0;
  logic         rx_line = 1'b1;
  logic         tx;
  logic         start_send = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         tx_busy;
  logic [W-1:0] out_data;
  logic         rx_valid;
  logic         rx_pop = 1'b0;
  logic         rx_frame_err, rx_parity_err, rx_overrun;
`ifdef UART_LOOPBACK_EN
  logic         loopback = 1'b0;
`endif

  uart_transceiver u_dut (
    .clk(clk), .reset(reset), .init(init), .rx(rx_line), .tx(tx),
    .start_send(start_send), .in_data(in_data), .tx_busy(tx_busy),
    .out_data(out_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
`ifdef UART_LOOPBACK_EN
    .loopback(loopback),
`endif
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun)
  );

  // ------------------------------------- instance 2 (8E1, DIV = 16) ---
  logic         p_init = 1'b0;
  logic         p_sel = 1'b0;
  logic         p_rx_drv = 1'b1;
  logic         p_rx, p_tx;
  logic         p_start = 1'b0;
  logic [W-1:0] p_in = '0;
  logic         p_busy;
  logic [W-1:0] p_out;
  logic         p_valid;
  logic         p_pop = 1'b0;
  logic         p_ferr, p_perr, p_ovr;

  assign p_rx = p_sel ? p_rx_drv : p_tx;

  uart_transceiver #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .PARITY(2)) u_par (
    .clk(clk), .reset(reset), .init(p_init), .rx(p_rx), .tx(p_tx),
    .start_send(p_start), .in_data(p_in), .tx_busy(p_busy),
    .out_data(p_out), .rx_valid(p_valid), .rx_pop(p_pop),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_frame_err(p_ferr), .rx_parity_err(p_perr), .rx_overrun(p_ovr)
  );

  // ------------------------------------------------------ scoreboard ---
  logic [W-1:0] exp_q[$];      // instance 1 RX bytes
  logic [9:0]   tx_exp_q[$];   // instance 1 tx frames, bit i = i-th bit on the line
  logic [W-1:0] p_exp_q[$];    // instance 2 RX bytes
  logic         pop_en = 1'b0;
  int           tx_frames = 0;
  int           ferr_cnt = 0, perr_cnt = 0, p_ferr_cnt = 0, p_perr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  always @(negedge clk) begin
    if (rx_frame_err === 1'b1)  ferr_cnt++;
    if (rx_parity_err === 1'b1) perr_cnt++;
    if (p_ferr === 1'b1)        p_ferr_cnt++;
    if (p_perr === 1'b1)        p_perr_cnt++;
  end

  // Instance 1 RX monitor: pops the head whenever popping is enabled.
  initial begin
    wait (reset === 1'b1);
    forever begin
      @(negedge clk);
      if (rx_pop) begin
        rx_pop = 1'b0;
      end else if (pop_en && rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: got %0h expected no data", out_data);
        end else begin
          check("rx_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        rx_pop = 1'b1;
      end
    end
  end

  // Instance 2 RX monitor: always pops.
  initial begin
    wait (reset === 1'b1);
    forever begin
      @(negedge clk);
      if (p_pop) begin
        p_pop = 1'b0;
      end else if (p_valid === 1'b1) begin
        if (p_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL p_rx_unexpected: got %0h expected no data", p_out);
        end else begin
          check("p_rx_data", 32'(p_out), 32'(p_exp_q.pop_front()));
        end
        p_pop = 1'b1;
      end
    end
  end

  // Instance 1 tx monitor: samples every bit of a frame at its centre.
  initial begin
    wait (reset === 1'b1);
    forever begin
      logic [9:0] f;
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (DIV1 / 2) @(negedge clk);
        f[0] = tx;
        for (int i = 1; i < 10; i++) begin
          repeat (DIV1) @(negedge clk);
          f[i] = tx;
        end
        tx_frames++;
        if (tx_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got frame %0h expected none", f);
        end else begin
          check("tx_frame", 32'(f), 32'(tx_exp_q.pop_front()));
        end
      end
    end
  end

  // ------------------------------------------------------ driver tasks ---
  task automatic drive_rx(input logic [W-1:0] d, input logic stop_bit);
    rx_line = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < W; i++) begin
      rx_line = d[i];
      #(BIT_NS);
    end
    rx_line = stop_bit;
    #(BIT_NS);
    rx_line = 1'b1;
    #(2 * BIT_NS);
  endtask

  task automatic drive_p(input logic [W-1:0] d, input logic par_bit);
    p_rx_drv = 1'b0;
    #(BIT2_NS);
    for (int i = 0; i < W; i++) begin
      p_rx_drv = d[i];
      #(BIT2_NS);
    end
    p_rx_drv = par_bit;
    #(BIT2_NS);
    p_rx_drv = 1'b1;
    #(3 * BIT2_NS);
  endtask

  task automatic wait_idle1(input string name);
    int c = 0;
    while (tx_busy === 1'b1 && c < 6000) begin
      c++;
      @(negedge clk);
    end
    if (c >= 6000) begin
      checks++; errors++;
      $display("FAIL %s: tx_busy still 1 after %0d cycles, required 0", name, c);
    end
  endtask

  // ---------------------------------------------------------- watchdog ---
  initial begin
    #1_800_000;
    checks++; errors++;
    $display("FAIL watchdog: run exceeded 1800000 ns, required completion");
    report();
    $finish;
  end

  // ---------------------------------------------------------- stimulus ---
  initial begin
    int c;
    int snap_f, snap_p;
    logic ps;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_out", 32'(out_data), 32'd0);
    check("reset_ovr", 32'(rx_overrun), 32'd0);
    check("reset_p_tx", 32'(p_tx), 32'd1);

    // Instance 2: even-parity frame 8'hA5 through tx -> rx loop.
    // A5 has four ones, so the parity bit is 0; 11 bits * 16 = 176 clocks.
    p_sel = 1'b0;
    p_in = 8'hA5;
    p_start = 1'b1;
    p_exp_q.push_back(8'hA5);
    @(negedge clk);
    p_start = 1'b0;
    c = 0;
    ps = 1'b1;
    while (p_busy === 1'b1 && c < 400) begin
      if (c == 9 * DIV2 + DIV2 / 2) ps = p_tx;
      c++;
      @(negedge clk);
    end
    check("p_busy_len", 32'(c), 32'd176);
    check("p_tx_parity_bit", 32'(ps), 32'd0);
    repeat (40) @(negedge clk);
    check("p_loop_drained", 32'(p_exp_q.size()), 32'd0);
    check("p_no_perr", 32'(p_perr_cnt), 32'd0);

    // Instance 2: A5 with parity bit 1 -> parity error, nothing stored.
    p_sel = 1'b1;
    drive_p(8'hA5, 1'b1);
    check("p_perr_pulse", 32'(p_perr_cnt), 32'd1);
    check("p_perr_no_data", 32'(p_valid), 32'd0);
    // 8'h07 has three ones, so a parity bit of 1 is correct.
    p_exp_q.push_back(8'h07);
    drive_p(8'h07, 1'b1);
    check("p_good_parity_drained", 32'(p_exp_q.size()), 32'd0);

    // Instance 2: init aborts a frame in flight.
    p_sel = 1'b0;
    p_in = 8'hFF;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    repeat (40) @(negedge clk);
    p_init = 1'b1;
    @(negedge clk);
    p_init = 1'b0;
    check("p_init_tx", 32'(p_tx), 32'd1);
    check("p_init_busy", 32'(p_busy), 32'd0);
    repeat (300) @(negedge clk);
    check("p_init_no_data", 32'(p_valid), 32'd0);
    check("p_init_no_ferr", 32'(p_ferr_cnt), 32'd0);

    // T1: 8'hCA -> line 0,0,1,0,1,0,0,1,1,1, busy for 4340 clocks.
    in_data = 8'hCA;
    start_send = 1'b1;
    tx_exp_q.push_back(10'b11_1001_0100);
    @(negedge clk);
    check("t1_busy_rise", 32'(tx_busy), 32'd1);
    check("t1_tx_low", 32'(tx), 32'd0);
    c = 0;
    while (tx_busy === 1'b1 && c < 6000) begin
      c++;
      @(negedge clk);
    end
    check("t1_busy_len", 32'(c), 32'd4340);

    // T2: start_send was held high across the frame; no retransmit.
    c = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx_busy === 1'b1) c++;
    end
    check("t1_hold_no_resend", 32'(c), 32'd0);
    start_send = 1'b0;
    repeat (3) @(negedge clk);
    // 8'h55 on the line: 0,1,0,1,0,1,0,1,0,1
    in_data = 8'h55;
    start_send = 1'b1;
    tx_exp_q.push_back(10'b10_1010_1010);
    repeat (1000) @(negedge clk);
    start_send = 1'b0;
    repeat (2) @(negedge clk);
    in_data = 8'h0F;
    start_send = 1'b1;   // edge while busy: dropped
    wait_idle1("t2_wait_idle");
    c = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx_busy === 1'b1) c++;
    end
    check("t2_no_queued_frame", 32'(c), 32'd0);
    check("t2_frames", 32'(tx_frames), 32'd2);
    check("t2_tx_drained", 32'(tx_exp_q.size()), 32'd0);
    start_send = 1'b0;

    // T3: framing error then the same bits with a good stop -> 8'h6D.
    drive_rx(8'h6D, 1'b0);
    check("t3_ferr_pulse", 32'(ferr_cnt), 32'd1);
    check("t3_ferr_no_data", 32'(rx_valid), 32'd0);
    pop_en = 1'b1;
    exp_q.push_back(8'h6D);
    drive_rx(8'h6D, 1'b1);
    check("t3_good_drained", 32'(exp_q.size()), 32'd0);
    check("t3_ovr_clear", 32'(rx_overrun), 32'd0);

    // T4: five frames with no pops; the fifth is dropped.
    pop_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(W'(k));
      drive_rx(W'(k), 1'b1);
    end
    check("t4_overrun", 32'(rx_overrun), 32'd1);
    check("t4_valid_full", 32'(rx_valid), 32'd1);
    pop_en = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_empty", 32'(rx_valid), 32'd0);
    check("t4_overrun_sticky", 32'(rx_overrun), 32'd1);

    // T5: false start.
    snap_f = ferr_cnt;
    snap_p = perr_cnt;
    rx_line = 1'b0;
    repeat (100) @(negedge clk);
    rx_line = 1'b1;
    repeat (2 * DIV1) @(negedge clk);
    check("t5_no_data", 32'(rx_valid), 32'd0);
    check("t5_no_ferr", 32'(ferr_cnt), 32'(snap_f));
    check("t5_no_perr", 32'(perr_cnt), 32'(snap_p));

    // init clears the sticky overrun.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    check("init_ovr_clear", 32'(rx_overrun), 32'd0);

`ifdef UART_LOOPBACK_EN
    // Loopback: 8'h3C returns through RX, tx pin stays high.
    loopback = 1'b1;
    @(negedge clk);
    in_data = 8'h3C;
    start_send = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    start_send = 1'b0;
    c = 0;
    while (tx_busy === 1'b1) begin
      if (tx !== 1'b1) c++;
      @(negedge clk);
      if (c > 6000) break;
    end
    repeat (DIV1) @(negedge clk);
    check("lb_tx_high", 32'(c), 32'd0);
    check("lb_drained", 32'(exp_q.size()), 32'd0);
    loopback = 1'b0;
`endif

    repeat (10) @(negedge clk);
    check("final_rx_q", 32'(exp_q.size()), 32'd0);
    check("final_p_q", 32'(p_exp_q.size()), 32'd0);
    report();
    $finish;
  end

endmodule
